// File: rtl/seq_feed_ctrl.sv
// Button-triggered serializer that feeds an 8-bit switch word to the sequence detector
// and gathers its match flag. Define SEQ_MSB_FIRST_EN to present bits MSB first.
module seq_feed_ctrl #(
  parameter int TICK_DIV = 100_000_000,
  parameter int NBITS    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             button,
  input  logic [NBITS-1:0] switch,
  input  logic             det_hit,
  output logic             bit_out,
  output logic             bit_valid,
  output logic             det_clr,
  output logic [2:0]       bit_idx,
  output logic             busy,
  output logic             done,
  output logic             led
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);
  // The strobe is registered, so it is raised one count early to line up with CNT_LAST.
  localparam logic [CW-1:0] CNT_PRE  = CW'(TICK_DIV - 2);
  localparam logic [2:0]    IDX_LAST = 3'(NBITS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_reg;
  logic             button_d_reg;
  logic             bit_valid_d1_reg;
  logic [CW-1:0]    cnt_reg;
  logic [2:0]       bit_cnt_reg;
  logic [NBITS-1:0] shift_reg;

  logic             start;
  logic             cur_bit;
  logic [NBITS-1:0] shift_next;

  assign start = button & ~button_d_reg;

`ifdef SEQ_MSB_FIRST_EN
  assign cur_bit    = shift_reg[NBITS-1];
  assign shift_next = shift_reg << 1;
`else
  assign cur_bit    = shift_reg[0];
  assign shift_next = shift_reg >> 1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= IDLE;
      button_d_reg     <= 1'b0;
      bit_valid_d1_reg <= 1'b0;
      cnt_reg          <= '0;
      bit_cnt_reg      <= '0;
      shift_reg        <= '0;
      bit_out          <= 1'b0;
      bit_valid        <= 1'b0;
      det_clr          <= 1'b0;
      bit_idx          <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      led              <= 1'b0;
    end else begin
      button_d_reg     <= button;
      bit_valid_d1_reg <= bit_valid;
      bit_valid        <= 1'b0;
      det_clr          <= 1'b0;
      done             <= 1'b0;

      // Detector answers one cycle after each strobe, in any state.
      if (bit_valid_d1_reg && det_hit) begin
        led <= 1'b1;
      end

      if (start) begin
        state_reg   <= RUN;
        shift_reg   <= switch;
        cnt_reg     <= '0;
        bit_cnt_reg <= '0;
        det_clr     <= 1'b1;
        led         <= 1'b0;
        busy        <= 1'b1;
      end else begin
        case (state_reg)
          IDLE: begin
            state_reg <= IDLE;
          end
          RUN: begin
            cnt_reg <= (cnt_reg == CNT_LAST) ? '0 : cnt_reg + CW'(1);
            if (cnt_reg == CNT_PRE) begin
              bit_valid   <= 1'b1;
              bit_out     <= cur_bit;
              bit_idx     <= bit_cnt_reg;
              shift_reg   <= shift_next;
              bit_cnt_reg <= bit_cnt_reg + 3'd1;
            end
            if (bit_valid && bit_idx == IDX_LAST) begin
              state_reg <= DONE;
              busy      <= 1'b0;
              done      <= 1'b1;
            end
          end
          DONE: begin
            state_reg <= IDLE;
          end
          default: begin
            state_reg <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_seq_feed_ctrl.sv
// Directed bench for seq_feed_ctrl at TICK_DIV=4, NBITS=8 with a one-cycle-latency
// detector model; expectations follow SEQ_MSB_FIRST_EN when the build defines it.
module tb_seq_feed_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       button = 1'b0;
  logic [7:0] switch = 8'h00;
  logic       det_hit = 1'b0;
  logic       bit_out, bit_valid, det_clr, busy, done, led;
  logic [2:0] bit_idx;

  int n_cmp = 0;
  int n_err = 0;
  int cur_n = 0;
  int hit_sel = -1;

  seq_feed_ctrl #(.TICK_DIV(4), .NBITS(8)) dut (
    .clk(clk), .rst(rst), .button(button), .switch(switch), .det_hit(det_hit),
    .bit_out(bit_out), .bit_valid(bit_valid), .det_clr(det_clr), .bit_idx(bit_idx),
    .busy(busy), .done(done), .led(led)
  );

  always #5 clk = ~clk;

  // Detector stand-in: registered match flag answering the strobe of bit hit_sel.
  always @(posedge clk) begin
    det_hit <= (hit_sel >= 0) && bit_valid && (bit_idx == 3'(hit_sel));
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @n=%0d: got %0h expected %0h", tag, cur_n, got, exp);
    end
  endtask

  function automatic logic exp_bit(input logic [7:0] sw, input int k);
`ifdef SEQ_MSB_FIRST_EN
    return sw[7-k];
`else
    return sw[k];
`endif
  endfunction

  // Cycle n counts negedges after the one where the start edge is driven (cycle T).
  task automatic run_case(input string name, input logic [7:0] sw, input logic [7:0] sw2,
                          input int hit_k, input int restart_at, input int hold);
    int n_end, base, m, k;
    logic [7:0] cur_sw;
    hit_sel = hit_k;
    @(negedge clk);
    button = 1'b1;
    switch = sw;
    n_end = 36 + restart_at;
    for (int n = 1; n <= n_end; n++) begin
      @(negedge clk);
      cur_n  = n;
      base   = (restart_at > 0 && n > restart_at) ? restart_at : 0;
      m      = n - base;
      cur_sw = (base > 0) ? sw2 : sw;
      check({name, ".det_clr"}, 32'(det_clr), 32'(m == 1));
      check({name, ".busy"}, 32'(busy), 32'(m >= 1 && m <= 32));
      check({name, ".done"}, 32'(done), 32'(m == 33));
      check({name, ".bit_valid"}, 32'(bit_valid), 32'((m % 4 == 0) && m <= 32));
      if ((m % 4 == 0) && m <= 32) begin
        k = m / 4 - 1;
        check({name, ".bit_idx"}, 32'(bit_idx), 32'(k));
        check({name, ".bit_out"}, 32'(bit_out), 32'(exp_bit(cur_sw, k)));
      end
      check({name, ".led"}, 32'(led), 32'(hit_k >= 0 && m >= 4 * hit_k + 6));
      if (n == restart_at) begin
        button = 1'b1;
        switch = sw2;
      end else if (n == hold || (restart_at > 0 && n == restart_at + 1)) begin
        button = 1'b0;
      end
    end
    for (int n = n_end + 1; n <= hold + 2; n++) begin
      @(negedge clk);
      cur_n = n;
      check({name, ".held_valid"}, 32'(bit_valid), 32'(0));
      check({name, ".held_busy"}, 32'(busy), 32'(0));
      check({name, ".held_done"}, 32'(done), 32'(0));
      if (n == hold) button = 1'b0;
    end
    button  = 1'b0;
    hit_sel = -1;
    $display("run %s sw=%h sw2=%h hit=%0d restart=%0d hold=%0d checked", name, sw, sw2, hit_k, restart_at, hold);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    cur_n = 0;
    check("rst.bit_out", 32'(bit_out), 32'(0));
    check("rst.bit_valid", 32'(bit_valid), 32'(0));
    check("rst.det_clr", 32'(det_clr), 32'(0));
    check("rst.bit_idx", 32'(bit_idx), 32'(0));
    check("rst.busy", 32'(busy), 32'(0));
    check("rst.done", 32'(done), 32'(0));
    check("rst.led", 32'(led), 32'(0));
    rst = 1'b0;
    $display("reset state checked");

    run_case("normal",  8'hA5, 8'h00, -1, 0, 1);
    run_case("hit",     8'hA5, 8'h00,  4, 0, 1);
    run_case("clear",   8'h3C, 8'h00, -1, 0, 1);
    run_case("lastbit", 8'hA5, 8'h00,  7, 0, 1);
    run_case("restart", 8'hA5, 8'hFF, -1, 13, 1);
    run_case("held",    8'h80, 8'h00, -1, 0, 100);

    // Reset asserted mid-run for three cycles.
    @(negedge clk);
    button = 1'b1;
    switch = 8'hFF;
    for (int n = 1; n <= 13; n++) begin
      @(negedge clk);
      cur_n = n;
      if (n == 1) button = 1'b0;
      if (n == 10) rst = 1'b1;
      if (n == 11) begin
        check("midrst.bit_out", 32'(bit_out), 32'(0));
        check("midrst.bit_valid", 32'(bit_valid), 32'(0));
        check("midrst.det_clr", 32'(det_clr), 32'(0));
        check("midrst.bit_idx", 32'(bit_idx), 32'(0));
        check("midrst.busy", 32'(busy), 32'(0));
        check("midrst.done", 32'(done), 32'(0));
        check("midrst.led", 32'(led), 32'(0));
      end
      if (n == 13) rst = 1'b0;
    end
    for (int n = 14; n <= 53; n++) begin
      @(negedge clk);
      cur_n = n;
      check("postrst.bit_valid", 32'(bit_valid), 32'(0));
      check("postrst.busy", 32'(busy), 32'(0));
      check("postrst.done", 32'(done), 32'(0));
    end
    $display("mid-run reset checked");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/seq_feed_ctrl.md
# seq_feed_ctrl

Sequencing controller for the serial sequence-detector datapath. On a button press it captures the 8-bit switch word, then presents it to the detector one bit per tick period with a one-cycle valid strobe. It clears the detector before each run, collects the detector's match flag into a sticky LED, and reports busy/done. It sits between the board I/O (button, switches, LED) and the detector FSM, replacing ad-hoc timer/flag logic.

## Interface
- `TICK_DIV`, default 100_000_000: clk cycles per presented bit; legal range ≥ 2.
- `NBITS`, default 8: bits per run; equals the width of `switch`.

Ports:
- `clk` input 1: system clock; all logic on the rising edge.
- `rst` input 1: reset; synchronous and active-high.
- `button` input 1: start request, level; already debounced/synchronised upstream; the block acts on its rising edge.
- `switch` input NBITS: sequence word, sampled only at start.
- `det_hit` input 1: detector match flag; registered in the detector, valid 1 cycle after `bit_valid`.
- `bit_out` output 1: current serial bit.
- `bit_valid` output 1: one-cycle strobe; the detector advances on it.
- `det_clr` output 1: one-cycle pulse forcing the detector to its initial state.
- `bit_idx` output 3: index of the bit just presented, 0..NBITS-1.
- `busy` output 1: high while a run is in progress.
- `done` output 1: one-cycle pulse at end of run.
- `led` output 1: sticky "sequence found in this run".

## Operation
- The FSM has three states: IDLE, RUN, DONE. All outputs are registered.
- **Reset values:** state=IDLE, bit_out=0, bit_valid=0, det_clr=0, bit_idx=0, busy=0, done=0, led=0. Internal `button_d`=0, tick counter=0, shift register=0.
- **Start event:** `button`=1 and `button_d`=0.
- **IDLE → RUN on start:**
  - Load the shift register with `switch`.
  - Clear the tick counter and bit counter.
  - Pulse `det_clr`, clear `led`, set `busy`.
- **RUN:**
  - The tick counter counts 0..TICK_DIV-1 and wraps to 0.
  - When the counter is at TICK_DIV-1:
    - Pulse `bit_valid`.
    - Drive `bit_out` with the current bit (LSB first by default) and set `bit_idx` to the bit count.
    - Shift the register and increment the bit count.
  - `bit_out` holds its value between strobes.
- **Hit capture:** in any cycle where the delayed strobe `bit_valid_d1`=1 and `det_hit`=1, `led` is set on the next edge. `led` stays set until the next start or reset.
- **RUN → DONE:** the cycle after the strobe for bit NBITS-1.
- **DONE:** lasts exactly one cycle, then returns to IDLE.
  - `done`=1 and `busy`=0 during this cycle.
  - `det_hit` is still sampled in this cycle, so a match on the last bit lights `led`.
- **Start while RUN or DONE:** restarts immediately. Same actions as IDLE → RUN, with the new `switch` value. The aborted run produces no `done`.
- **Button held high:** only one start per rising edge; no auto-repeat.
- `rst` overrides everything, including a simultaneous start.

## Timing
- Start edge sampled at edge T. At T+1: busy=1, det_clr=1 (one cycle), led=0, counter=0.
- Bit k strobe (`bit_valid`=1, `bit_idx`=k) at cycle T+(k+1)·TICK_DIV, for k=0..NBITS-1.
- `done` pulse at T+NBITS·TICK_DIV+1. `busy` falls in the same cycle.
- `led` rises 2 cycles after the strobe of the bit that produced the hit.
- Restart latency is 1 cycle from the start edge, in every state.
- Counter width is ceil(log2(TICK_DIV)). Bit counter is 3 bits; `bit_idx` never exceeds NBITS-1.

## Configuration
- `SEQ_MSB_FIRST_EN`
  - Defined: bits are presented MSB first (`switch[NBITS-1]` at k=0) and the register shifts left.
  - Undefined (default): LSB first (`switch[0]` at k=0) and the register shifts right.
  - Nothing else changes.

## Test plan
All scenarios use TICK_DIV=4 and NBITS=8.
- **Reset:** assert rst for 3 cycles mid-run → all outputs 0 next cycle; no strobe until a new button edge.
- **Normal run:** switch=8'b1010_0101, button edge at T → det_clr at T+1. Strobes at T+4, T+8, …, T+32 with bit_out 1,0,1,0,0,1,0,1 and bit_idx 0..7. done at T+33; busy high from T+1 to T+32.
- **Hit capture:** detector model raises det_hit after the strobe at T+20 → led=1 at T+22, held through done and afterwards. The next start clears it at T'+1.
- **Last-bit hit:** det_hit asserted only in response to the bit-7 strobe (T+32) → led=1 at T+34; done still pulses at T+33.
- **Restart mid-run:** second button edge at T+13 with switch=8'hFF → det_clr at T+14, bit 0 (=1) strobed at T+17, no done until T+46.
- **Held button and MSB-first:** button held high for 100 cycles → exactly one run. Rebuild with SEQ_MSB_FIRST_EN and switch=8'h80 → bit_out=1 only at the k=0 strobe.
